// File: rtl/eth_pattern_responder_pkg.sv
// Shared constants, FSM state type and request classification helper for the
// test-pattern responder.
package eth_pattern_responder_pkg;

    localparam logic [15:0] ETH_TYPE_PATTERN_REQ  = 16'h88B5;
    localparam logic [15:0] ETH_TYPE_PATTERN_RESP = 16'h88B6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR_OUT = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    function automatic logic is_request(input logic [15:0] eth_type,
                                        input logic [15:0] type0,
                                        input logic [15:0] type1);
        return (eth_type == type0) || (eth_type == type1);
    endfunction

endpackage

// File: rtl/eth_pattern_responder_skid.sv
// Two-entry AXI-stream skid buffer. Input ready comes straight from a register
// (skid slot empty), so it never depends combinationally on the output ready.
module axis_skid_buffer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    logic [WIDTH-1:0] data_p0;
    logic [WIDTH-1:0] data_p1;
    logic             vld_p0;
    logic             vld_p1;

    // Occupancy of the output slot (p0) and the skid slot (p1)
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (!vld_p0 || m_ready) begin
            if (vld_p1) begin
                vld_p0 <= 1'b1;
                vld_p1 <= 1'b0;
            end else begin
                vld_p0 <= s_valid;
            end
        end else if (s_valid && !vld_p1) begin
            vld_p1 <= 1'b1;
        end
    end

    // Data slots: output slot refills from skid first, skid captures during a stall
    always_ff @(posedge clk) begin
        if (!vld_p0 || m_ready) begin
            data_p0 <= vld_p1 ? data_p1 : s_data;
        end else if (!vld_p1) begin
            data_p1 <= s_data;
        end
    end

    assign s_ready = !vld_p1;
    assign m_valid = vld_p0;
    assign m_data  = data_p0;

endmodule

// File: rtl/eth_pattern_responder.sv
// Test-pattern responder: accepts 0x88B5/0x88B6 request frames, swaps MACs,
// rewrites the EtherType and echoes the payload; everything else is dropped.
module eth_pattern_responder
    import eth_pattern_responder_pkg::*;
#(
    parameter int          DATA_WIDTH = 8,
    parameter logic [15:0] REQ_TYPE0  = ETH_TYPE_PATTERN_REQ,
    parameter logic [15:0] REQ_TYPE1  = ETH_TYPE_PATTERN_RESP,
    parameter logic [15:0] RESP_TYPE  = ETH_TYPE_PATTERN_RESP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [47:0]           local_mac,
    input  logic                  s_eth_hdr_valid,
    output logic                  s_eth_hdr_ready,
    input  logic [47:0]           s_eth_dest_mac,
    input  logic [47:0]           s_eth_src_mac,
    input  logic [15:0]           s_eth_type,
    input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
    input  logic                  s_eth_payload_axis_tvalid,
    output logic                  s_eth_payload_axis_tready,
    input  logic                  s_eth_payload_axis_tlast,
    input  logic                  s_eth_payload_axis_tuser,
    output logic                  m_eth_hdr_valid,
    input  logic                  m_eth_hdr_ready,
    output logic [47:0]           m_eth_dest_mac,
    output logic [47:0]           m_eth_src_mac,
    output logic [15:0]           m_eth_type,
    output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
    output logic                  m_eth_payload_axis_tvalid,
    input  logic                  m_eth_payload_axis_tready,
    output logic                  m_eth_payload_axis_tlast,
    output logic                  m_eth_payload_axis_tuser,
    output logic [31:0]           rx_frame_count,
    output logic [31:0]           tx_frame_count,
    output logic [31:0]           drop_count,
    output logic [31:0]           error_count
);

    localparam int BUF_W = DATA_WIDTH + 2;

    state_t           state;
    state_t           state_next;
    logic             req_match;
    logic             hdr_accept;
    logic             s_pay_fire;
    logic             m_pay_fire;
    logic             in_done;
    logic             buf_s_valid;
    logic             buf_s_ready;
    logic             buf_m_valid;
    logic [BUF_W-1:0] buf_m_data;
    logic             unused_dest_parity;

    // The request destination MAC carries no information for the response
    assign unused_dest_parity = ^s_eth_dest_mac;

    assign req_match  = enable && is_request(s_eth_type, REQ_TYPE0, REQ_TYPE1);
    assign hdr_accept = s_eth_hdr_valid && s_eth_hdr_ready;
    assign s_pay_fire = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
    assign m_pay_fire = m_eth_payload_axis_tvalid && m_eth_payload_axis_tready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; PAYLOAD only ends once the final beat has left the buffer
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (s_eth_hdr_valid) state_next = req_match ? ST_HDR_OUT : ST_DROP;
            ST_HDR_OUT: if (m_eth_hdr_ready) state_next = ST_PAYLOAD;
            ST_PAYLOAD: if (m_pay_fire && m_eth_payload_axis_tlast) state_next = ST_IDLE;
            ST_DROP:    if (s_eth_payload_axis_tvalid && s_eth_payload_axis_tlast) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state
    always_comb begin
        s_eth_hdr_ready           = 1'b0;
        m_eth_hdr_valid           = 1'b0;
        s_eth_payload_axis_tready = 1'b0;
        buf_s_valid               = 1'b0;
        case (state)
            ST_IDLE:    s_eth_hdr_ready = 1'b1;
            ST_HDR_OUT: m_eth_hdr_valid = 1'b1;
            ST_PAYLOAD: begin
                s_eth_payload_axis_tready = buf_s_ready && !in_done;
                buf_s_valid               = s_eth_payload_axis_tvalid && !in_done;
            end
            ST_DROP:    s_eth_payload_axis_tready = 1'b1;
            default:    s_eth_hdr_ready = 1'b0;
        endcase
    end

    // Block further input once the request's last beat is in, until the response drains
    always_ff @(posedge clk) begin
        if (rst || state != ST_PAYLOAD) begin
            in_done <= 1'b0;
        end else if (s_pay_fire && s_eth_payload_axis_tlast) begin
            in_done <= 1'b1;
        end
    end

    // Response header fields, captured when a matching request header is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            m_eth_dest_mac <= '0;
            m_eth_src_mac  <= '0;
            m_eth_type     <= '0;
        end else if (state == ST_IDLE && hdr_accept && req_match) begin
            m_eth_dest_mac <= s_eth_src_mac;
            m_eth_src_mac  <= local_mac;
            m_eth_type     <= RESP_TYPE;
        end
    end

    // Free-running statistics; each counter wraps naturally at 32 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_frame_count <= '0;
            tx_frame_count <= '0;
            drop_count     <= '0;
            error_count    <= '0;
        end else begin
            if (hdr_accept) begin
                rx_frame_count <= rx_frame_count + 32'd1;
                if (!req_match) drop_count <= drop_count + 32'd1;
            end
            if (m_eth_hdr_valid && m_eth_hdr_ready) begin
                tx_frame_count <= tx_frame_count + 32'd1;
            end
            if (state == ST_PAYLOAD && s_pay_fire &&
                s_eth_payload_axis_tlast && s_eth_payload_axis_tuser) begin
                error_count <= error_count + 32'd1;
            end
        end
    end

    axis_skid_buffer #(
        .WIDTH (BUF_W)
    ) u_payload_buf (
        .clk     (clk),
        .rst     (rst),
        .s_data  ({s_eth_payload_axis_tlast, s_eth_payload_axis_tuser, s_eth_payload_axis_tdata}),
        .s_valid (buf_s_valid),
        .s_ready (buf_s_ready),
        .m_data  (buf_m_data),
        .m_valid (buf_m_valid),
        .m_ready (m_eth_payload_axis_tready)
    );

    assign {m_eth_payload_axis_tlast, m_eth_payload_axis_tuser, m_eth_payload_axis_tdata} = buf_m_data;
    assign m_eth_payload_axis_tvalid = buf_m_valid;

endmodule

// File: tb/tb_eth_pattern_responder.sv
// Self-checking bench for eth_pattern_responder: a frame-level reference model
// queues the expected response headers and beats, a monitor compares every
// output handshake against it and checks stall stability.
module tb_eth_pattern_responder;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b1;
    logic [47:0]   local_mac = 48'h07_08_09_0a_0b_0c;
    logic          s_eth_hdr_valid = 1'b0;
    logic          s_eth_hdr_ready;
    logic [47:0]   s_eth_dest_mac = 48'hff_ff_ff_ff_ff_ff;
    logic [47:0]   s_eth_src_mac = '0;
    logic [15:0]   s_eth_type = '0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic          s_tuser = 1'b0;
    logic          m_eth_hdr_valid;
    logic          m_eth_hdr_ready = 1'b1;
    logic [47:0]   m_eth_dest_mac;
    logic [47:0]   m_eth_src_mac;
    logic [15:0]   m_eth_type;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic          m_tuser;
    logic [31:0]   rx_frame_count, tx_frame_count, drop_count, error_count;

    eth_pattern_responder #(.DATA_WIDTH(DW)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .enable                    (enable),
        .local_mac                 (local_mac),
        .s_eth_hdr_valid           (s_eth_hdr_valid),
        .s_eth_hdr_ready           (s_eth_hdr_ready),
        .s_eth_dest_mac            (s_eth_dest_mac),
        .s_eth_src_mac             (s_eth_src_mac),
        .s_eth_type                (s_eth_type),
        .s_eth_payload_axis_tdata  (s_tdata),
        .s_eth_payload_axis_tvalid (s_tvalid),
        .s_eth_payload_axis_tready (s_tready),
        .s_eth_payload_axis_tlast  (s_tlast),
        .s_eth_payload_axis_tuser  (s_tuser),
        .m_eth_hdr_valid           (m_eth_hdr_valid),
        .m_eth_hdr_ready           (m_eth_hdr_ready),
        .m_eth_dest_mac            (m_eth_dest_mac),
        .m_eth_src_mac             (m_eth_src_mac),
        .m_eth_type                (m_eth_type),
        .m_eth_payload_axis_tdata  (m_tdata),
        .m_eth_payload_axis_tvalid (m_tvalid),
        .m_eth_payload_axis_tready (m_tready),
        .m_eth_payload_axis_tlast  (m_tlast),
        .m_eth_payload_axis_tuser  (m_tuser),
        .rx_frame_count            (rx_frame_count),
        .tx_frame_count            (tx_frame_count),
        .drop_count                (drop_count),
        .error_count               (error_count)
    );

    always #4 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    typedef struct {
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] etype;
    } hdr_t;

    int          tests = 0;
    int          fails = 0;
    beat_t       exp_beats[$];
    hdr_t        exp_hdrs[$];
    logic [7:0]  pl[$];
    int          exp_rx = 0, exp_tx = 0, exp_drop = 0, exp_err = 0;
    logic        rdy_random = 1'b0;
    logic        rst_window = 1'b1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        tests++;
        fails++;
        $display("FAIL timeout %s: observed no handshake, required one within bound", tag);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // Output-side ready generators, updated shortly after each rising edge
    always @(posedge clk) begin
        #2;
        m_tready        = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
        m_eth_hdr_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: values at the falling edge are exactly what the next rising edge samples
    logic         prev_pv = 1'b0, prev_pr = 1'b0, prev_hv = 1'b0, prev_hr = 1'b0;
    logic [9:0]   prev_word = '0;
    logic [111:0] prev_hdr = '0;
    beat_t        mon_b;
    hdr_t         mon_h;

    always @(negedge clk) begin
        if (rst_window) begin
            prev_pv = 1'b0;
            prev_hv = 1'b0;
        end else begin
            if (prev_pv && !prev_pr) begin
                check("pay_hold_valid", 128'(m_tvalid), 128'(1'b1));
                check("pay_hold_data", 128'({m_tlast, m_tuser, m_tdata}), 128'(prev_word));
            end
            if (prev_hv && !prev_hr) begin
                check("hdr_hold_valid", 128'(m_eth_hdr_valid), 128'(1'b1));
                check("hdr_hold_fields", 128'({m_eth_dest_mac, m_eth_src_mac, m_eth_type}), 128'(prev_hdr));
            end
            if (m_eth_hdr_valid && m_eth_hdr_ready) begin
                if (exp_hdrs.size() == 0) begin
                    check("unexpected_hdr", 128'(exp_hdrs.size()), 128'(1));
                end else begin
                    mon_h = exp_hdrs.pop_front();
                    check("hdr_dest", 128'(m_eth_dest_mac), 128'(mon_h.dest));
                    check("hdr_src", 128'(m_eth_src_mac), 128'(mon_h.src));
                    check("hdr_type", 128'(m_eth_type), 128'(mon_h.etype));
                end
            end
            if (m_tvalid && m_tready) begin
                if (exp_beats.size() == 0) begin
                    check("unexpected_beat", 128'(exp_beats.size()), 128'(1));
                end else begin
                    mon_b = exp_beats.pop_front();
                    check("beat", 128'({m_tlast, m_tuser, m_tdata}), 128'({mon_b.last, mon_b.user, mon_b.data}));
                end
            end
            prev_pv   = m_tvalid;
            prev_pr   = m_tready;
            prev_word = {m_tlast, m_tuser, m_tdata};
            prev_hv   = m_eth_hdr_valid;
            prev_hr   = m_eth_hdr_ready;
            prev_hdr  = {m_eth_dest_mac, m_eth_src_mac, m_eth_type};
        end
    end

    task automatic check_counters(input string tag);
        check({tag, "_rx"}, 128'(rx_frame_count), 128'(exp_rx));
        check({tag, "_tx"}, 128'(tx_frame_count), 128'(exp_tx));
        check({tag, "_drop"}, 128'(drop_count), 128'(exp_drop));
        check({tag, "_err"}, 128'(error_count), 128'(exp_err));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_beats.size() != 0 || exp_hdrs.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 5000) timeout("drain");
        end
        repeat (3) @(negedge clk);
    endtask

    // Send one frame whose payload is in pl[]; called at a falling edge.
    // rst_beat >= 0 resets the DUT while that beat is offered; flip_beat toggles enable mid-frame.
    task automatic send_frame(input logic [15:0] etype, input logic [47:0] src,
                              input logic last_user, input int rst_beat, input int flip_beat);
        logic  match;
        beat_t b;
        int    n;
        match = enable && (etype == 16'h88B5 || etype == 16'h88B6);
        exp_rx++;
        if (match) begin
            exp_tx++;
            exp_hdrs.push_back('{dest: src, src: local_mac, etype: 16'h88B6});
            for (int i = 0; i < pl.size(); i++) begin
                b.data = pl[i];
                b.last = (i == pl.size() - 1);
                b.user = b.last && last_user;
                exp_beats.push_back(b);
            end
            if (last_user) exp_err++;
        end else begin
            exp_drop++;
        end
        s_eth_hdr_valid = 1'b1;
        s_eth_src_mac   = src;
        s_eth_type      = etype;
        n = 0;
        while (!s_eth_hdr_ready) begin
            @(negedge clk);
            n++;
            if (n > 3000) timeout("hdr_accept");
        end
        @(negedge clk);
        s_eth_hdr_valid = 1'b0;
        for (int i = 0; i < pl.size(); i++) begin
            if (i == flip_beat) enable = ~enable;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            s_tvalid = 1'b1;
            s_tdata  = pl[i];
            s_tlast  = (i == pl.size() - 1);
            s_tuser  = s_tlast && last_user;
            if (i == rst_beat) begin
                rst        = 1'b1;
                rst_window = 1'b1;
                @(negedge clk);
                rst      = 1'b0;
                s_tvalid = 1'b0;
                exp_beats.delete();
                exp_hdrs.delete();
                exp_rx = 0; exp_tx = 0; exp_drop = 0; exp_err = 0;
                check("rst_hdr_valid", 128'(m_eth_hdr_valid), 128'(1'b0));
                check("rst_pay_valid", 128'(m_tvalid), 128'(1'b0));
                check("rst_hdr_ready", 128'(s_eth_hdr_ready), 128'(1'b1));
                check_counters("rst");
                @(negedge clk);
                rst_window = 1'b0;
                return;
            end
            n = 0;
            while (!s_tready) begin
                @(negedge clk);
                n++;
                if (n > 3000) timeout("payload_accept");
            end
            @(negedge clk);
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            s_tuser  = 1'b0;
        end
    endtask

    task automatic fill_random(input int len);
        pl.delete();
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_hdr_ready", 128'(s_eth_hdr_ready), 128'(1'b1));
        check("reset_hdr_valid", 128'(m_eth_hdr_valid), 128'(1'b0));
        check("reset_pay_valid", 128'(m_tvalid), 128'(1'b0));
        check("reset_dest", 128'(m_eth_dest_mac), 128'(0));
        check_counters("reset");
        @(negedge clk);
        rst_window = 1'b0;

        // 1: basic echo, 56 incrementing bytes
        pl.delete();
        for (int i = 0; i < 56; i++) pl.push_back(8'(i));
        send_frame(16'h88B5, 48'h01_02_03_04_05_06, 1'b0, -1, -1);
        drain();
        check_counters("t1");

        // 2: non-matching EtherType is dropped
        fill_random(20);
        send_frame(16'h0800, 48'h0a_0b_0c_0d_0e_0f, 1'b0, -1, -1);
        drain();
        check_counters("t2");

        // 3: 100 frames with random output back-pressure
        rdy_random = 1'b1;
        for (int f = 0; f < 100; f++) begin
            fill_random(64);
            send_frame(($urandom_range(0, 1) != 0) ? 16'h88B5 : 16'h88B6, {16'h0200, 32'($urandom)}, 1'b0, -1, -1);
        end
        drain();
        check_counters("t3");

        // 4: disabled for 3 frames (enable returns mid-frame 3), then enabled for 2
        enable = 1'b0;
        for (int f = 0; f < 3; f++) begin
            fill_random(16);
            send_frame(16'h88B5, {16'h0300, 32'($urandom)}, 1'b0, -1, (f == 2) ? 5 : -1);
        end
        for (int f = 0; f < 2; f++) begin
            fill_random(16);
            send_frame(16'h88B6, {16'h0400, 32'($urandom)}, 1'b0, -1, -1);
        end
        drain();
        check_counters("t4");

        // 5: tuser on the final beat, then a single-beat frame
        fill_random(10);
        send_frame(16'h88B5, 48'h05_05_05_05_05_05, 1'b1, -1, -1);
        fill_random(1);
        send_frame(16'h88B6, 48'h06_06_06_06_06_06, 1'b0, -1, -1);
        drain();
        check_counters("t5");

        // 6: reset on beat 20 of 64, then a clean frame
        fill_random(64);
        send_frame(16'h88B5, 48'h08_08_08_08_08_08, 1'b0, 20, -1);
        fill_random(64);
        send_frame(16'h88B5, 48'h09_09_09_09_09_09, 1'b0, -1, -1);
        drain();
        check_counters("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
